leaf_gpu_ingress_buffer: RTL and testbench
==========================================

Name: leaf_gpu_ingress_buffer

Overview:
- Ingress buffer between a GPU port and the leaf router's GPU input (gpu_in_data / gpu_in_valid / gpu_dest_addr).
- The leaf router carries no FIFOs and ties its gpu_fifo_in_* status to 0; this block supplies the real buffering and the status flags for those outputs.
- Accepts fire-and-forget flits from the GPU and queues {dest, data} in a FIFO.
- Presents the head flit through a registered output stage to the router with a valid/ready handshake, and counts dropped flits.

Parameters:
- DWIDTH, 16, flit payload width.
- AWIDTH, 6, destination address width: [5:2] = group, [1:0] = router.
- FIFO_DEPTH, 8, storage entries; power of two, at least 4.
- AF_LEVEL, 6, almost_full threshold in entries.
- GROUP_ID, 4'b0010, own group for the destination check.
- ROUTER_ID, 1, own router index; the low 2 bits are used.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = in reset.
- in_data  in  DWIDTH  GPU flit payload.
- in_dest  in  AWIDTH  GPU flit destination.
- in_valid  in  1  flit present this cycle; no ready (fire-and-forget).
- out_data  out  DWIDTH  head flit payload, to router gpu_in_data.
- out_dest  out  AWIDTH  head flit destination, to router gpu_dest_addr.
- out_valid  out  1  to router gpu_in_valid.
- out_ready  in  1  crossbar accepts the output flit this cycle.
- fifo_full  out  1  storage full; drives gpu_fifo_in_full.
- fifo_empty  out  1  storage empty AND output stage empty; drives gpu_fifo_in_empty.
- almost_full  out  1  occupancy >= AF_LEVEL.
- occupancy  out  $clog2(FIFO_DEPTH)+1  storage entries used; excludes the output register.
- drop_count  out  8  saturating count of dropped flits.
- err_dest  out  1  one-cycle pulse on a rejected destination (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - Read/write pointers = 0, occupancy = 0.
  - out_valid = 0; out_data and out_dest = 0.
  - drop_count = 0; err_dest = 0; fifo_full = 0; fifo_empty = 1; almost_full = 0.
  - Assertion mid-transfer discards all contents. Release is sampled synchronously; the first push is possible on the first edge with reset=1.
- Storage:
  - Circular buffer of FIFO_DEPTH {dest, data} entries.
  - Pointers are $clog2(FIFO_DEPTH)+1 bits; the extra MSB disambiguates full from empty.
  - Pointers wrap modulo FIFO_DEPTH.
- Push:
  - Occurs on an edge where in_valid=1 and storage is not full (evaluated pre-edge).
  - If storage is full, the flit is dropped and drop_count increments, saturating at 255 (holds at 255).
  - A pop of storage into the output register in the same cycle does NOT free space for that cycle's push. Full is judged on pre-edge occupancy.
- Output stage:
  - load = storage not empty AND (out_valid=0 OR out_ready=1).
  - On load: out_data/out_dest <= head entry, out_valid <= 1, read pointer advances.
  - Else if out_valid=1 and out_ready=1: out_valid <= 0.
  - Else: hold. out_data and out_dest are stable while out_valid=1 and out_ready=0.
  - Sustains one flit per cycle when out_ready is held 1.
- Latency: a flit pushed at edge N into empty storage, with the output stage free, has out_valid=1 after edge N+1. There is no push-to-output bypass.
- Occupancy:
  - Simultaneous push and load leaves occupancy unchanged.
  - Total capacity = FIFO_DEPTH + 1, counting the output register.
- Ordering: strict FIFO; no reordering, duplication or loss except the defined drops.
- Flags: fifo_full, almost_full and occupancy are combinational from the pointers and reflect post-edge state.

Optional Feature:
- Macro: LEAF_INGRESS_DEST_CHECK_EN.
- Defined: an incoming flit is rejected when in_dest == {GROUP_ID[3:0], ROUTER_ID[1:0]} (a self-address loop).
  - A rejected flit is not pushed.
  - drop_count increments (saturating).
  - err_dest pulses 1 for the cycle after the offending edge.
  - The check takes priority over full: a self-addressed flit arriving while full counts as one drop and raises err_dest.
- Not defined: every flit is treated normally; err_dest is constant 0.

Test Plan:
- Reset then idle: after release, out_valid=0, fifo_empty=1, occupancy=0, drop_count=0.
- Single flit 16'hA5A5 with dest 6'b000101 pushed at edge N, out_ready=1: out_valid=1 with 16'hA5A5 / 6'b000101 after edge N+1; out_valid=0 after edge N+2.
- Fill and overflow: out_ready=0, push 12 flits 0..11 on consecutive cycles.
  - Flit 0 is in the output register; flits 1..8 are stored; flits 9..11 are dropped.
  - Result: drop_count=3, fifo_full=1, occupancy=8, almost_full=1.
  - Then out_ready=1: outputs 0..8 appear in order on 9 consecutive cycles.
- Backpressure hold: with out_valid=1, toggle out_ready 0/1 every cycle.
  - out_data is stable on every ready=0 cycle; a new flit appears only after each ready=1 edge.
  - Sequence of 20 flits is intact.
- Saturation plus mid-operation reset:
  - Force 300 drops: drop_count=255.
  - Assert reset for 1 ns mid-stream: all outputs return to reset values immediately, without waiting for a clock edge.
- With LEAF_INGRESS_DEST_CHECK_EN defined, GROUP_ID=4'b0010, ROUTER_ID=1:
  - Push dest 6'b001001: rejected; err_dest=1 for one cycle; drop_count +1; occupancy unchanged.
  - Push dest 6'b001010: accepted.

Source files
------------

// File: rtl/leaf_gpu_ingress_buffer.sv
// Ingress FIFO with a registered output stage between a GPU port and the leaf router.
// Optional self-address rejection is compiled in with LEAF_INGRESS_DEST_CHECK_EN.
`timescale 1ns/1ps
module leaf_gpu_ingress_buffer #(
  parameter int         DWIDTH     = 16,
  parameter int         AWIDTH     = 6,
  parameter int         FIFO_DEPTH = 8,
  parameter int         AF_LEVEL   = 6,
  parameter logic [3:0] GROUP_ID   = 4'b0010,
  parameter int         ROUTER_ID  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DWIDTH-1:0]             in_data,
  input  logic [AWIDTH-1:0]             in_dest,
  input  logic                          in_valid,
  output logic [DWIDTH-1:0]             out_data,
  output logic [AWIDTH-1:0]             out_dest,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic                          almost_full,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy,
  output logic [7:0]                    drop_count,
  output logic                          err_dest
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef struct packed {
    logic [AWIDTH-1:0] dest;
    logic [DWIDTH-1:0] data;
  } entry_t;

  entry_t            mem_q [FIFO_DEPTH];
  entry_t            out_entry_q;
  logic              out_valid_q;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  occ;
  logic [7:0]        drop_count_q;
  logic              err_dest_q;
  logic              store_full, store_empty;
  logic              self_hit, push, drop, load;

`ifdef LEAF_INGRESS_DEST_CHECK_EN
  localparam logic [AWIDTH-1:0] SELF_ADDR = AWIDTH'({GROUP_ID, 2'(ROUTER_ID)});
  assign self_hit = (in_dest == SELF_ADDR);
`else
  assign self_hit = 1'b0;
`endif

  // Extra pointer MSB makes the subtraction distinguish full from empty.
  assign occ         = wr_ptr_q - rd_ptr_q;
  assign store_full  = (occ == PTR_W'(FIFO_DEPTH));
  assign store_empty = (occ == '0);

  // Full is judged on pre-edge occupancy, so a same-cycle load never frees room.
  assign push = in_valid && !self_hit && !store_full;
  assign drop = in_valid && (self_hit || store_full);
  assign load = !store_empty && (!out_valid_q || out_ready);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (load) rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  // NOTE: storage array has no reset; validity is tracked solely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[IDX_W-1:0]] <= '{dest: in_dest, data: in_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_entry_q  <= '0;
      drop_count_q <= '0;
      err_dest_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_dest_q <= in_valid && self_hit;
      if (drop && drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 8'd1;
      if (load) begin
        out_entry_q <= mem_q[rd_ptr_q[IDX_W-1:0]];
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data    = out_entry_q.data;
  assign out_dest    = out_entry_q.dest;
  assign out_valid   = out_valid_q;
  assign fifo_full   = store_full;
  assign fifo_empty  = store_empty && !out_valid_q;
  assign almost_full = (occ >= PTR_W'(AF_LEVEL));
  assign occupancy   = occ;
  assign drop_count  = drop_count_q;
  assign err_dest    = err_dest_q;

endmodule

// File: tb/tb_leaf_gpu_ingress_buffer.sv
// Scoreboard bench for leaf_gpu_ingress_buffer: queue-based reference model plus
// a negedge monitor that pops expected flits on every output handshake.
`timescale 1ns/1ps
module tb_leaf_gpu_ingress_buffer;

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam logic [5:0] SELF = 6'b001001;

  typedef struct packed {
    logic [5:0]  dest;
    logic [15:0] data;
  } flit_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in_data = '0;
  logic [5:0]  in_dest = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [5:0]  out_dest;
  logic        out_valid;
  logic        fifo_full, fifo_empty, almost_full, err_dest;
  logic [3:0]  occupancy;
  logic [7:0]  drop_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  flit_t m_store[$];
  flit_t sb_q[$];
  bit    m_ov = 1'b0;
  int    m_drops = 0;
  bit    m_err = 1'b0;
  bit    dest_chk = 1'b0;
  bit    mon_en = 1'b0;
  bit    hold_prev = 1'b0;
  flit_t hold_val;

  leaf_gpu_ingress_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_dest     (in_dest),
    .in_valid    (in_valid),
    .out_data    (out_data),
    .out_dest    (out_dest),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .almost_full (almost_full),
    .occupancy   (occupancy),
    .drop_count  (drop_count),
    .err_dest    (err_dest)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec rules applied to the model on each rising edge, using pre-edge state.
  task automatic model_edge();
    bit was_full, is_self, ld;
    was_full = (m_store.size() == DEPTH);
    is_self  = dest_chk && (in_dest == SELF);
    ld       = (m_store.size() > 0) && (!m_ov || out_ready);
    if (ld) begin
      void'(m_store.pop_front());
      m_ov = 1'b1;
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end
    m_err = in_valid && is_self;
    if (in_valid) begin
      if (is_self || was_full) begin
        if (m_drops < 255) m_drops++;
      end else begin
        m_store.push_back('{dest: in_dest, data: in_data});
        sb_q.push_back('{dest: in_dest, data: in_data});
      end
    end
  endtask

  task automatic step(input bit v, input logic [15:0] d, input logic [5:0] a, input bit r);
    in_valid  = v;
    in_data   = d;
    in_dest   = a;
    out_ready = r;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Monitor: compares flags every cycle and pops the scoreboard on each handshake.
  initial begin
    flit_t exp_f;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("occupancy", 32'(occupancy), 32'(m_store.size()));
        check("fifo_full", 32'(fifo_full), 32'(m_store.size() == DEPTH));
        check("almost_full", 32'(almost_full), 32'(m_store.size() >= AF));
        check("fifo_empty", 32'(fifo_empty), 32'(m_store.size() == 0 && !m_ov));
        check("drop_count", 32'(drop_count), 32'(m_drops));
        check("err_dest", 32'(err_dest), 32'(m_err));
        if (hold_prev) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", 32'({out_dest, out_data}), 32'(hold_val));
        end
        hold_prev = out_valid && !out_ready;
        hold_val  = '{dest: out_dest, data: out_data};
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
          end else begin
            exp_f = sb_q.pop_front();
            check("out_flit", 32'({out_dest, out_data}), 32'(exp_f));
          end
        end
      end
    end
  end

  initial begin
`ifdef LEAF_INGRESS_DEST_CHECK_EN
    dest_chk = 1'b1;
`endif
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fifo_empty", 32'(fifo_empty), 32'd1);
    #10 reset = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Reset then idle
    step(0, '0, '0, 1);
    check("idle_occupancy", 32'(occupancy), 32'd0);
    check("idle_drop_count", 32'(drop_count), 32'd0);
    check("idle_fifo_empty", 32'(fifo_empty), 32'd1);

    // Single flit latency
    step(1, 16'hA5A5, 6'b000101, 1);
    check("lat_n_valid", 32'(out_valid), 32'd0);
    step(0, '0, '0, 1);
    check("lat_n1_valid", 32'(out_valid), 32'd1);
    check("lat_n1_data", 32'(out_data), 32'hA5A5);
    check("lat_n1_dest", 32'(out_dest), 32'h05);
    step(0, '0, '0, 1);
    check("lat_n2_valid", 32'(out_valid), 32'd0);

    // Fill and overflow
    for (int i = 0; i < 12; i++) step(1, 16'(i), 6'(i), 0);
    check("fill_drops", 32'(drop_count), 32'd3);
    check("fill_full", 32'(fifo_full), 32'd1);
    check("fill_occ", 32'(occupancy), 32'd8);
    check("fill_af", 32'(almost_full), 32'd1);
    check("fill_head", 32'(out_data), 32'd0);
    for (int i = 0; i < 12; i++) step(0, '0, '0, 1);
    check("fill_drained", 32'(sb_q.size()), 32'd0);

    // Backpressure: ready toggles every cycle, push every other cycle
    for (int i = 0; i < 40; i++) step(i % 2 == 0, 16'h1000 + 16'(i / 2), 6'(i / 2), i % 2 == 1);
    for (int i = 0; i < 40; i++) step(0, '0, '0, i % 2 == 1);
    check("bp_drained", 32'(sb_q.size()), 32'd0);

    // Drop-count saturation
    for (int i = 0; i < 300; i++) step(1, 16'(i), 6'b000100, 0);
    check("sat_drop_count", 32'(drop_count), 32'd255);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) step(1, 16'h7000 + 16'(i), 6'b000011, 1);
    #1 reset = 1'b0;
    #0.5;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    check("arst_out_dest", 32'(out_dest), 32'd0);
    check("arst_occ", 32'(occupancy), 32'd0);
    check("arst_drops", 32'(drop_count), 32'd0);
    check("arst_full", 32'(fifo_full), 32'd0);
    check("arst_empty", 32'(fifo_empty), 32'd1);
    check("arst_af", 32'(almost_full), 32'd0);
    check("arst_err", 32'(err_dest), 32'd0);
    m_store.delete();
    sb_q.delete();
    m_ov = 1'b0;
    m_drops = 0;
    m_err = 1'b0;
    hold_prev = 1'b0;
    #0.5 reset = 1'b1;

    // Destination check
    step(1, 16'hBEEF, SELF, 0);
    check("dc_err", 32'(err_dest), 32'(dest_chk));
    check("dc_occ", 32'(occupancy), dest_chk ? 32'd0 : 32'd1);
    check("dc_drops", 32'(drop_count), 32'(dest_chk));
    step(1, 16'hCAFE, 6'b001010, 0);
    check("dc_err_clear", 32'(err_dest), 32'd0);
    for (int i = 0; i < 4; i++) step(0, '0, '0, 1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic [5:0] a;
      a = ($urandom_range(0, 7) == 0) ? SELF : 6'($urandom);
      step($urandom_range(0, 9) < 6, 16'($urandom), a, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 20; i++) step(0, '0, '0, 1);
    check("final_drained", 32'(sb_q.size()), 32'd0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
